sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_ctrl_pkg.sv | 13 +
 rtl/sync_fifo_ctrl_fifo_ptr.sv | 23 ++
 rtl/sync_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared defaults for the synchronous FIFO controller: widths and flag thresholds.
package sync_fifo_ctrl_pkg;

   localparam int DEF_AW     = 5;
   localparam int DEF_DW     = 16;
   localparam int DEF_AEMPTY = 2;

   // almost_full sits two words below full unless overridden.
   function automatic int afull_default(input int aw);
      return (2 ** aw) - 2;
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_fifo_ptr.sv
// Wrapping FIFO pointer: one extra MSB distinguishes full from empty.
module fifo_ptr #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Pointer register: flush beats increment, wraps modulo 2**W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a dual-port RAM with a
// registered read port; hides the RAM's read-during-write X with a bypass.
module sync_fifo_ctrl
   import sync_fifo_ctrl_pkg::*;
#(
   parameter int AW     = DEF_AW,
   parameter int DW     = DEF_DW,
   parameter int AFULL  = afull_default(AW),
   parameter int AEMPTY = DEF_AEMPTY
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          ram_rclk,
   output logic          ram_wclk,
   output logic          ram_rrst,
   output logic          ram_wrst,
   output logic          ram_rce,
   output logic          ram_oe,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_do,
   output logic          ram_wce,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_di
);

   localparam logic [AW:0] DEPTH_C  = (AW+1)'(2 ** AW);
   localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL);
   localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push;
   logic          pop;
   logic          collision;
   logic          byp_sel_q;
   logic [DW-1:0] byp_data_q;

   fifo_ptr #(.W(AW+1)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.W(AW+1)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   // Occupancy and flags come straight from the registered pointers.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   // Handshakes: write side ignores rd_ready so a full FIFO never takes a word.
   assign wr_ready = !full;
   assign rd_valid = !empty;
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   // RAM port drives; the read address looks one pop ahead so the RAM
   // always holds the next head in its output register.
   assign ram_rclk  = clk;
   assign ram_wclk  = clk;
   assign ram_rrst  = 1'b0;
   assign ram_wrst  = 1'b0;
   assign ram_rce   = 1'b1;
   assign ram_oe    = 1'b1;
   assign ram_we    = push;
   assign ram_wce   = push;
   assign ram_waddr = wr_ptr[AW-1:0];
   assign ram_di    = wr_data;
   assign ram_raddr = rd_ptr[AW-1:0] + AW'(pop);

   // Writing the word the RAM is reading this cycle yields X from the RAM.
   assign collision = push && (ram_waddr == ram_raddr);

   // Remember whether next cycle's head must come from the bypass register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_sel_q <= 1'b0;
      end else if (clr) begin
         byp_sel_q <= 1'b0;
      end else begin
         byp_sel_q <= collision;
      end
   end

   // Capture the write data every cycle; only used when byp_sel_q is set.
   always_ff @(posedge clk) begin
      byp_data_q <= wr_data;
   end

   assign rd_data = byp_sel_q ? byp_data_q : ram_do;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised self-checking bench for sync_fifo_ctrl against a queue model.
module tb_sync_fifo_ctrl;

   localparam int AW    = 2;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clr = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty;
   logic          ram_rclk, ram_wclk, ram_rrst, ram_wrst, ram_rce, ram_oe;
   logic [AW-1:0] ram_raddr, ram_waddr;
   logic [DW-1:0] ram_do, ram_di;
   logic          ram_wce, ram_we;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [DW-1:0] q[$];

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.AW(AW), .DW(DW), .AFULL(3), .AEMPTY(1)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .ram_rclk(ram_rclk), .ram_wclk(ram_wclk), .ram_rrst(ram_rrst), .ram_wrst(ram_wrst),
      .ram_rce(ram_rce), .ram_oe(ram_oe), .ram_raddr(ram_raddr), .ram_do(ram_do),
      .ram_wce(ram_wce), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_di(ram_di)
   );

   // Behavioural dual-port RAM: registered read, X on same-address read/write.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ram_do_q;
   always @(posedge ram_wclk)
      if (ram_we && ram_wce) mem[ram_waddr] <= ram_di;
   always @(posedge ram_rclk)
      if (ram_rce) ram_do_q <= (ram_we && ram_wce && ram_waddr == ram_raddr) ? 'x : mem[ram_raddr];
   assign ram_do = ram_oe ? ram_do_q : 'x;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Compare every visible output with what the queue model says.
   task automatic check_outputs();
      int n;
      n = q.size();
      check("count",        32'(count),        32'(n));
      check("empty",        32'(empty),        32'(n == 0));
      check("full",         32'(full),         32'(n == DEPTH));
      check("almost_full",  32'(almost_full),  32'(n >= 3));
      check("almost_empty", 32'(almost_empty), 32'(n <= 1));
      check("wr_ready",     32'(wr_ready),     32'(n < DEPTH));
      check("rd_valid",     32'(rd_valid),     32'(n > 0));
      if (n > 0) check("rd_data", 32'(rd_data), 32'(q[0]));
   endtask

   // One clock of stimulus: drive, update model at the edge, check at negedge.
   task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic c);
      int  n;
      bit  psh, pp;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      clr      = c;
      n   = q.size();
      psh = wv && (n < DEPTH);
      pp  = rr && (n > 0);
      #1;
      check("no_overflow",  32'(wr_valid & wr_ready & full), 32'(0));
      check("no_underflow", 32'(rd_valid & rd_ready & empty), 32'(0));
      @(posedge clk);
      if (c) q.delete();
      else begin
         if (pp) void'(q.pop_front());
         if (psh) q.push_back(wd);
      end
      cyc++;
      $display("cyc %0d wv=%b wd=%h rr=%b clr=%b push=%b pop=%b occ=%0d",
               cyc, wv, wd, rr, c, psh, pp, q.size());
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int sent;
      int guard;
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs();

      // Reset mid-traffic: asynchronous, visible before any clock edge.
      cycle(1'b1, 16'h0001, 1'b0, 1'b0);
      cycle(1'b1, 16'h0002, 1'b0, 1'b0);
      wr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs();

      // Fill to full, then a rejected fifth write.
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'h000A + 16'(i), 1'b0, 1'b0);
      check("full_at_4", 32'(full), 32'(1));
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);

      // Fall-through into empty, then push/pop at count 1.
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0011, 1'b0, 1'b0);
      cycle(1'b1, 16'h0022, 1'b1, 1'b0);
      check("pushpop_head", 32'(rd_data), 32'h0022);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);

      // Stream 12 words with random stalls on both sides.
      sent  = 0;
      guard = 0;
      while ((sent < 12 || q.size() > 0) && guard < 300) begin
         logic wv;
         wv = (sent < 12) && ($urandom_range(3) != 0);
         if (wv && q.size() < DEPTH) begin
            cycle(1'b1, 16'h0100 + 16'(sent), $urandom_range(2) != 0, 1'b0);
            sent++;
         end else begin
            cycle(wv, 16'h0100 + 16'(sent), $urandom_range(2) != 0, 1'b0);
         end
         guard++;
      end
      check("stream_done", 32'(guard < 300), 32'(1));

      // Flush beats push and pop at count 3.
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'h0BAD, 1'b1, 1'b1);
      check("clr_empty", 32'(empty), 32'(1));
      cycle(1'b1, 16'h0300, 1'b0, 1'b0);

      // Random soak with occasional flush.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)), $urandom_range(24) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
